button_debounce_ctrl: RTL and testbench

// - Avalon-MM slave controller for the pong push-buttons, built on the raw button PIO input.
// - Per button: 2-FF synchronizer, counter-based debounce, press-edge capture.
// - Also keeps a 16-bit total-press counter and an optional masked interrupt.
// - Sits between the board buttons and the Nios bus; game software reads clean state/events.

---
 rtl/button_debounce_ctrl.sv | 154 +++++++++++++++
 tb/tb_button_debounce_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/button_debounce_ctrl.sv
// Avalon-MM push-button controller: per-lane sync + debounce, sticky press edges, press counter.
// Optional masked level interrupt when BTN_IRQ_EN is defined; otherwise irq is tied low.

module button_debounce_lane #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_pin,
  output logic o_state,
  output logic o_press
);
  localparam logic             RELEASED = (ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {ST_STABLE, ST_COUNT} st_t;

  st_t              r_st;
  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic             r_state, r_press;
  logic             w_p;

  // Sync FFs reset to the released pin level so leaving reset never looks like a press.
  always_ff @(posedge clk) begin
    if (reset) r_sync <= {2{RELEASED}};
    else       r_sync <= {r_sync[0], i_pin};
  end

  assign w_p = (ACTIVE_LOW != 0) ? ~r_sync[1] : r_sync[1];

  // The first differing cycle counts as 1, so acceptance lands DEBOUNCE_CYCLES after sync.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_st    <= ST_STABLE;
      r_cnt   <= '0;
      r_state <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_press <= 1'b0;
      case (r_st)
        ST_STABLE:
          if (w_p != r_state) begin
            r_st  <= ST_COUNT;
            r_cnt <= CNT_W'(1);
          end
        ST_COUNT:
          if (w_p == r_state) begin
            r_st  <= ST_STABLE;
            r_cnt <= '0;
          end else if (r_cnt == LIMIT) begin
            r_st    <= ST_STABLE;
            r_cnt   <= '0;
            r_state <= w_p;
            r_press <= w_p;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        default: r_st <= ST_STABLE;
      endcase
    end
  end

  assign o_state = r_state;
  assign o_press = r_press;
endmodule

module button_debounce_ctrl #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);
  logic [WIDTH-1:0] w_state, w_press, w_mask, w_clr;
  logic [WIDTH-1:0] r_edge;
  logic [15:0]      r_presses, w_npress;
  logic             w_unused;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    button_debounce_lane #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_lane (
      .clk    (clk),
      .reset  (reset),
      .i_pin  (in_port[i]),
      .o_state(w_state[i]),
      .o_press(w_press[i])
    );
  end

  always_comb begin
    w_npress = '0;
    for (int i = 0; i < WIDTH; i++) w_npress = w_npress + 16'(w_press[i]);
  end

  assign w_clr    = (write && address == 2'd2) ? writedata[WIDTH-1:0] : '0;
  assign w_unused = &{1'b0, writedata[31:WIDTH]};

  // Press set is OR'd after the clear so a same-cycle event beats W1C.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_edge    <= '0;
      r_presses <= '0;
    end else begin
      r_edge <= (r_edge & ~w_clr) | w_press;
      if (write && address == 2'd3) r_presses <= '0;
      else                          r_presses <= r_presses + w_npress;
    end
  end

`ifdef BTN_IRQ_EN
  logic [WIDTH-1:0] r_mask;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mask <= '0;
      irq    <= 1'b0;
    end else begin
      if (write && address == 2'd1) r_mask <= writedata[WIDTH-1:0];
      irq <= |(r_edge & r_mask);
    end
  end

  assign w_mask = r_mask;
`else
  assign w_mask = '0;
  assign irq    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) readdata <= '0;
    else begin
      case (address)
        2'd0:    readdata <= 32'(w_state);
        2'd1:    readdata <= 32'(w_mask);
        2'd2:    readdata <= 32'(r_edge);
        default: readdata <= 32'(r_presses);
      endcase
    end
  end
endmodule

// File: tb/tb_button_debounce_ctrl.sv
// Directed bench for button_debounce_ctrl with DEBOUNCE_CYCLES=8, WIDTH=4, active-low pins.
// Checks reset, debounce latency, bounce rejection, W1C races, irq, counter wrap and mid-debounce reset.

module tb_button_debounce_ctrl;
  localparam int WIDTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  in_port;
  logic        irq;

  int n_cmp = 0;
  int n_err = 0;

  button_debounce_ctrl #(
    .WIDTH(WIDTH), .DEBOUNCE_CYCLES(8), .CNT_W(4), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .write(write),
    .writedata(writedata), .readdata(readdata), .in_port(in_port), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] e, input string tag);
    address = a;
    tick(1);
    chk(tag, readdata, e);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; write = 1'b1;
    tick(1);
    write = 1'b0;
  endtask

`ifdef BTN_IRQ_EN
  localparam logic [31:0] MASK_RB = 32'h4;
  localparam logic        IRQ_ON  = 1'b1;
`else
  localparam logic [31:0] MASK_RB = 32'h0;
  localparam logic        IRQ_ON  = 1'b0;
`endif

  initial begin
    reset = 1'b1; address = 2'd0; write = 1'b0; writedata = '0; in_port = 4'hF;
    tick(3);
    reset = 1'b0;
    chk("reset readdata", readdata, 32'h0);
    chk("reset irq", 32'(irq), 32'h0);
    tick(20);
    rd(2'd0, 32'h0, "idle STATE");
    rd(2'd2, 32'h0, "idle EDGE");
    rd(2'd3, 32'h0, "idle PRESSES");
    rd(2'd1, 32'h0, "idle MASK");
    chk("idle irq", 32'(irq), 32'h0);

    // bit 0 press: state flips on the 10th edge, readdata shows it one edge later
    address = 2'd0;
    in_port = 4'hE;
    tick(10);
    chk("bit0 before accept", readdata, 32'h0);
    tick(1);
    chk("bit0 accepted", readdata, 32'h1);
    rd(2'd2, 32'h1, "bit0 EDGE");
    rd(2'd3, 32'h1, "bit0 PRESSES");

    // bit 1 bounces in 3-cycle runs, then held
    for (int k = 0; k < 6; k++) begin
      in_port[1] = k[0];
      tick(3);
    end
    in_port[1] = 1'b0;
    tick(12);
    rd(2'd0, 32'h3, "bounce STATE");
    rd(2'd2, 32'h3, "bounce EDGE");
    rd(2'd3, 32'h2, "bounce PRESSES");

    // release and re-press bit 0; W1C lands in the same cycle as the press event
    in_port = 4'hD;
    tick(12);
    rd(2'd0, 32'h2, "bit0 released STATE");
    rd(2'd2, 32'h3, "release no event EDGE");
    address = 2'd0;
    in_port = 4'hC;
    tick(10);
    wr(2'd2, 32'h1);
    rd(2'd2, 32'h3, "set beats W1C");
    rd(2'd3, 32'h3, "repress PRESSES");

    wr(2'd2, 32'h1);
    rd(2'd2, 32'h2, "plain W1C");

    // mask bit 2 and press it
    wr(2'd1, 32'h4);
    rd(2'd1, MASK_RB, "MASK readback");
    chk("irq before press", 32'(irq), 32'h0);
    in_port = 4'h8;
    tick(11);
    chk("irq as EDGE sets", 32'(irq), 32'h0);
    tick(1);
    chk("irq asserted", 32'(irq), 32'(IRQ_ON));
    wr(2'd2, 32'h4);
    chk("irq during clear", 32'(irq), 32'(IRQ_ON));
    tick(1);
    chk("irq cleared", 32'(irq), 32'h0);
    rd(2'd2, 32'h2, "EDGE after clear");
    rd(2'd3, 32'h4, "bit2 PRESSES");

    // counter wrap
    force dut.r_presses = 16'hFFFF;
    tick(1);
    release dut.r_presses;
    rd(2'd3, 32'hFFFF, "preload PRESSES");
    in_port = 4'h0;
    tick(12);
    rd(2'd3, 32'h0, "wrap PRESSES");
    rd(2'd2, 32'hA, "wrap EDGE");
    rd(2'd0, 32'hF, "all pressed STATE");

    // release everything, then any write clears PRESSES
    in_port = 4'h8;
    tick(12);
    in_port = 4'hF;
    tick(12);
    rd(2'd0, 32'h0, "all released STATE");
    wr(2'd3, 32'h0);
    rd(2'd3, 32'h0, "write-clear PRESSES");

    // reset while bit 3 is mid-count (cnt=5)
    address = 2'd0;
    in_port = 4'h7;
    tick(7);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("mid reset readdata", readdata, 32'h0);
    chk("mid reset irq", 32'(irq), 32'h0);
    tick(10);
    chk("post reset before accept", readdata, 32'h0);
    tick(1);
    chk("post reset accepted", readdata, 32'h8);
    rd(2'd2, 32'h8, "post reset EDGE");
    rd(2'd3, 32'h1, "post reset PRESSES");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
